// File: rtl/cache_pkg.sv
// Shared types for the cache refill controller: FSM state encoding and default widths.
package cache_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        FILL    = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc until every bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss-handling FSM between the core port, a fully associative cache and main memory.
// Write-through / write-allocate; load hits answer in the request cycle.
module cache_refill_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_write,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_valid,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [DATA_WIDTH-1:0] cache_wdata_r;
    logic                  mem_req_valid_r;
    logic                  mem_req_write_r;
    logic                  cache_write_r;
    logic                  cache_valid_r;
    logic                  idle_s;
    logic                  hit_inc_s;
    logic                  miss_inc_s;
    logic                  req_ready_s;
    logic [DATA_WIDTH-1:0] resp_rdata_s;

    assign idle_s     = (state_r == IDLE);
    assign hit_inc_s  = idle_s && req_valid && !req_write && cache_hit;
    assign miss_inc_s = idle_s && req_valid && !req_write && !cache_hit;

    // Zero-latency hit path plus completion strobes decoded from the registered state.
    always_comb begin
        req_ready_s  = 1'b0;
        resp_rdata_s = '0;
        if (hit_inc_s) begin
            req_ready_s  = 1'b1;
            resp_rdata_s = cache_rdata;
        end else if (state_r == FILL) begin
            req_ready_s  = 1'b1;
            resp_rdata_s = rdata_r;
        end else if ((state_r == WR_WAIT) && mem_resp_valid) begin
            req_ready_s  = 1'b1;
        end else begin
            req_ready_s  = 1'b0;
            resp_rdata_s = '0;
        end
    end

    // Refill / write-through FSM; every strobe toward cache and memory is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            addr_r          <= '0;
            wdata_r         <= '0;
            rdata_r         <= '0;
            cache_wdata_r   <= '0;
            mem_req_valid_r <= 1'b0;
            mem_req_write_r <= 1'b0;
            cache_write_r   <= 1'b0;
            cache_valid_r   <= 1'b0;
        end else begin
            cache_write_r <= 1'b0;
            cache_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        if (req_write) begin
                            // Store writes the cache on the first WR_REQ cycle only.
                            state_r         <= WR_REQ;
                            cache_write_r   <= 1'b1;
                            cache_valid_r   <= 1'b1;
                            cache_wdata_r   <= req_wdata;
                            mem_req_valid_r <= 1'b1;
                            mem_req_write_r <= 1'b1;
                        end else if (!cache_hit) begin
                            state_r         <= RD_REQ;
                            mem_req_valid_r <= 1'b1;
                            mem_req_write_r <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= RD_WAIT;
                    end else begin
                        state_r <= RD_REQ;
                    end
                end
                RD_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_r       <= mem_resp_rdata;
                        cache_wdata_r <= mem_resp_rdata;
                        cache_write_r <= 1'b1;
                        cache_valid_r <= 1'b1;
                        state_r       <= FILL;
                    end else begin
                        state_r <= RD_WAIT;
                    end
                end
                FILL: begin
                    state_r <= IDLE;
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        mem_req_write_r <= 1'b0;
                        state_r         <= WR_WAIT;
                    end else begin
                        state_r <= WR_REQ;
                    end
                end
                WR_WAIT: begin
                    if (mem_resp_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_WAIT;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    mem_req_valid_r <= 1'b0;
                    mem_req_write_r <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc_s),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_inc_s),
        .count (miss_count)
    );

    assign req_ready     = req_ready_s;
    assign resp_rdata    = resp_rdata_s;
    assign cache_addr    = idle_s ? req_addr : addr_r;
    assign cache_write   = cache_write_r;
    assign cache_valid   = cache_valid_r;
    assign cache_wdata   = cache_wdata_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_write = mem_req_write_r;
    assign mem_req_addr  = addr_r;
    assign mem_req_wdata = wdata_r;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized self-checking bench: emulated cache array and memory, plus a transaction-level reference model.
module tb_cache_refill_controller;

    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic [31:0]   resp_rdata;
    logic [31:0]   cache_addr;
    logic          cache_write;
    logic [31:0]   cache_wdata;
    logic          cache_valid;
    logic          cache_hit;
    logic [31:0]   cache_rdata;
    logic          mem_req_valid;
    logic          mem_req_write;
    logic [31:0]   mem_req_addr;
    logic [31:0]   mem_req_wdata;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int check_cnt;
    int error_cnt;

    // Emulated cache array (16 word slots) written by the DUT's fill/store pulses.
    logic          cache_clr;
    logic [15:0]   cvalid;
    logic [31:0]   cdata [16];

    // Reference model: expected cache contents, memory image, counters.
    bit            ref_valid [16];
    logic [31:0]   ref_data  [16];
    logic [31:0]   mem       [16];
    int            hit_ref;
    int            miss_ref;

    cache_refill_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_rdata(resp_rdata),
        .cache_addr(cache_addr), .cache_write(cache_write), .cache_wdata(cache_wdata),
        .cache_valid(cache_valid), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cache_hit   = cvalid[cache_addr[5:2]];
        cache_rdata = cache_hit ? cdata[cache_addr[5:2]] : 32'd0;
    end

    always @(posedge clk) begin
        if (cache_clr) begin
            cvalid <= 16'd0;
        end else if (cache_write) begin
            cvalid[cache_addr[5:2]] <= cache_valid;
            cdata[cache_addr[5:2]]  <= cache_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    // One core transaction; memory stalls 'stall' cycles then answers 'lat' cycles after accept.
    task automatic do_req(input logic wr, input logic [3:0] idx, input logic [31:0] d,
                          input int stall, input int lat);
        logic [31:0] a, exp_data, got, m_addr, m_wdata, c_wdata;
        logic        m_write, c_valid;
        bit          exp_hit, accepted, done, stable_ok, responded;
        int          cyc, mem_cycles, cache_wrs, stall_left, resp_in, ready_cyc, exp_lat;
        a = {26'd0, idx, 2'b00};
        exp_hit  = !wr && ref_valid[idx];
        exp_data = wr ? d : (exp_hit ? ref_data[idx] : mem[idx]);
        exp_lat  = exp_hit ? 0 : (wr ? 1 + stall + lat : 2 + stall + lat);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        cyc = 0; done = 0; accepted = 0; stable_ok = 1; responded = 0;
        mem_cycles = 0; cache_wrs = 0; stall_left = stall; resp_in = 0; ready_cyc = -1;
        m_addr = 32'd0; m_wdata = 32'd0; m_write = 1'b0; c_wdata = 32'd0; c_valid = 1'b0; got = 32'd0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
            if (resp_in > 0) begin
                resp_in--;
                if (resp_in == 0 && !responded) begin
                    responded = 1;
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem[m_addr[5:2]];
                end
            end
            if (mem_req_valid && !accepted) begin
                if (mem_cycles == 0) begin
                    m_addr = mem_req_addr; m_write = mem_req_write; m_wdata = mem_req_wdata;
                end else if (mem_req_addr !== m_addr || mem_req_write !== m_write || mem_req_wdata !== m_wdata) begin
                    stable_ok = 0;
                end
                mem_cycles++;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1; accepted = 1; resp_in = lat;
                    if (mem_req_write) mem[mem_req_addr[5:2]] = mem_req_wdata;
                end
            end
            #1;
            if (cache_write) begin cache_wrs++; c_wdata = cache_wdata; c_valid = cache_valid; end
            if (req_ready) begin done = 1; ready_cyc = cyc; got = resp_rdata; end
            cyc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        if (wr) begin
            ref_valid[idx] = 1; ref_data[idx] = d;
        end else if (exp_hit) begin
            hit_ref = sat_inc(hit_ref);
        end else begin
            miss_ref = sat_inc(miss_ref); ref_valid[idx] = 1; ref_data[idx] = exp_data;
        end
        check("latency", ready_cyc, exp_lat);
        if (!wr) check("resp_rdata", got, exp_data);
        check("mem_accept", {31'd0, accepted}, exp_hit ? 32'd0 : 32'd1);
        check("cache_writes", cache_wrs, exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit) begin
            check("mem_addr", m_addr, a);
            check("mem_write", {31'd0, m_write}, {31'd0, wr});
            if (wr) check("mem_wdata", m_wdata, d);
            check("mem_valid_cycles", mem_cycles, stall + 1);
            check("mem_stable", {31'd0, stable_ok}, 32'd1);
            check("cache_wdata", c_wdata, exp_data);
            check("cache_valid", {31'd0, c_valid}, 32'd1);
        end
        check("hit_count", {30'd0, hit_count}, hit_ref);
        check("miss_count", {30'd0, miss_count}, miss_ref);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_quiet", {29'd0, req_ready, mem_req_valid, cache_write}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        check_cnt = 0; error_cnt = 0; hit_ref = 0; miss_ref = 0;
        reset = 1'b1; cache_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 0; ref_data[i] = 32'd0; mem[i] = $urandom;
        end
        mem[4] = 32'h0000CAFE;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; cache_clr = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_strobes", {28'd0, mem_req_valid, mem_req_write, cache_write, cache_valid}, 32'd0);
        check("rst_counters", {28'd0, hit_count, miss_count}, 32'd0);
        check("rst_resp", resp_rdata, 32'd0);
        @(posedge clk); #1;

        do_req(1'b0, 4'd4, 32'd0, 0, 2);             // load 0x10 miss -> 0xCAFE
        do_req(1'b0, 4'd4, 32'd0, 0, 1);             // load 0x10 hit
        do_req(1'b1, 4'd5, 32'h0000BEEF, 3, 1);      // store 0x14 with 3-cycle stall
        idle_cycle();
        do_req(1'b0, 4'd5, 32'd0, 0, 1);             // load 0x14 hits 0xBEEF
        for (int i = 0; i < 5; i++) do_req(1'b0, 4'd4, 32'd0, 0, 1);
        check("hit_saturated", {30'd0, hit_count}, 32'd3);

        // Reset while waiting for memory, then a stale response arrives.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h24; req_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rd_req_valid", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        reset = 1'b1; req_valid = 1'b0;
        #1;
        check("mid_rst_strobes", {29'd0, req_ready, mem_req_valid, cache_write}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
        #1;
        check("stale_resp_ready", {30'd0, req_ready, cache_write}, 32'd0);
        @(posedge clk); #1 mem_resp_valid = 1'b0;
        @(negedge clk);
        check("stale_no_fill", {30'd0, cache_write, mem_req_valid}, 32'd0);
        check("rst_cnt_clear", {28'd0, hit_count, miss_count}, 32'd0);
        hit_ref = 0; miss_ref = 0;
        @(posedge clk); #1;
        do_req(1'b0, 4'd4, 32'd0, 0, 1);             // IDLE again: 0x10 still hits

        for (int n = 0; n < 80; n++) begin
            do_req(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
                   $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
